// File: rtl/servo_ramp_profile.sv
// Single-axis servo position ramp generator with a trapezoidal velocity profile.
// The profile updates once per prescaler tick. It accelerates, cruises at the
// speed limit, then decelerates so that the position lands exactly on the target.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start_pos  move start position (sampled on go)
//   end_pos    move target position (sampled on go)
//   max_speed  cruise velocity in counts/tick, 0 treated as 1 (sampled on go)
//   accel      velocity change per tick, 0 treated as 1 (sampled on go)
//   tick_div   profile update every tick_div+1 clocks (sampled on go)
//   go         start/restart a move; highest priority
//   abort      stop the move at the current position
//   busy       move in progress
//   rdy        ~busy
//   done       one-cycle pulse on arrival, or on a zero-length move
//   aborted    sticky abort flag, cleared by go or reset
//   out_cmp    current position, drives the PWM comparator
module servo_ramp_profile #(
    parameter int unsigned CNTR_BITS = 16,
    parameter int unsigned DIV_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CNTR_BITS-1:0] start_pos,
    input  logic [CNTR_BITS-1:0] end_pos,
    input  logic [CNTR_BITS-1:0] max_speed,
    input  logic [CNTR_BITS-1:0] accel,
    input  logic [DIV_BITS-1:0]  tick_div,
    input  logic                 go,
    input  logic                 abort,
    output logic                 busy,
    output logic                 rdy,
    output logic                 done,
    output logic                 aborted,
    output logic [CNTR_BITS-1:0] out_cmp
);

    typedef enum logic [1:0] {StIdle, StAccel, StCruise, StDecel} state_e;

    state_e               state_q;
    logic [CNTR_BITS-1:0] cur_q, end_q, vmax_q, acc_q, vel_q, ramp_q;
    logic [DIV_BITS-1:0]  presc_q, div_q;
    logic                 done_q, aborted_q;

    // Per-tick datapath
    logic                 tick;
    logic                 up;
    logic [CNTR_BITS-1:0] rem;
    logic [CNTR_BITS:0]   vel_sum;
    logic [CNTR_BITS-1:0] vel_n;
    logic [CNTR_BITS-1:0] step_src;
    logic [CNTR_BITS-1:0] step;
    logic [CNTR_BITS-1:0] left;
    logic [CNTR_BITS:0]   ramp_sum;
    logic [CNTR_BITS-1:0] ramp_n;
    logic [CNTR_BITS-1:0] vel_dec;

    always_comb begin
        tick     = (presc_q == div_q);
        up       = (end_q >= cur_q);
        rem      = up ? (end_q - cur_q) : (cur_q - end_q);
        // One extra bit so vel+acc cannot wrap before the speed clamp
        vel_sum  = {1'b0, vel_q} + {1'b0, acc_q};
        vel_n    = (vel_sum > {1'b0, vmax_q}) ? vmax_q : vel_sum[CNTR_BITS-1:0];
        step_src = (state_q == StAccel) ? vel_n : vel_q;
        // Clamping the step to the remaining distance prevents overshoot and wrap-around
        step     = (step_src < rem) ? step_src : rem;
        left     = rem - step;
        ramp_sum = {1'b0, ramp_q} + {1'b0, step};
        ramp_n   = ramp_sum[CNTR_BITS] ? '1 : ramp_sum[CNTR_BITS-1:0];
        // Deceleration floors at 1 so the axis never stalls short of the target
        vel_dec  = (vel_q > acc_q) ? (vel_q - acc_q) : CNTR_BITS'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cur_q     <= '0;
            end_q     <= '0;
            vmax_q    <= '0;
            acc_q     <= '0;
            div_q     <= '0;
            vel_q     <= '0;
            ramp_q    <= '0;
            presc_q   <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (go) begin
                cur_q     <= start_pos;
                end_q     <= end_pos;
                vmax_q    <= (max_speed == '0) ? CNTR_BITS'(1) : max_speed;
                acc_q     <= (accel == '0) ? CNTR_BITS'(1) : accel;
                div_q     <= tick_div;
                vel_q     <= '0;
                ramp_q    <= '0;
                presc_q   <= '0;
                aborted_q <= 1'b0;
                if (start_pos == end_pos) begin
                    state_q <= StIdle;
                    done_q  <= 1'b1;
                end else begin
                    state_q <= StAccel;
                end
            end else if (abort && state_q != StIdle) begin
                state_q   <= StIdle;
                end_q     <= cur_q;
                vel_q     <= '0;
                presc_q   <= '0;
                aborted_q <= 1'b1;
            end else if (state_q != StIdle) begin
                if (tick) begin
                    presc_q <= '0;
                    cur_q   <= up ? (cur_q + step) : (cur_q - step);
                    if (left == '0) begin
                        state_q <= StIdle;
                        vel_q   <= '0;
                        done_q  <= 1'b1;
                    end else begin
                        case (state_q)
                            StAccel: begin
                                vel_q  <= vel_n;
                                ramp_q <= ramp_n;
                                if (left <= ramp_n) begin
                                    state_q <= StDecel;
                                end else if (vel_n == vmax_q) begin
                                    state_q <= StCruise;
                                end
                            end
                            StCruise: begin
                                if (left <= ramp_q) begin
                                    state_q <= StDecel;
                                end
                            end
                            StDecel: begin
                                vel_q <= vel_dec;
                            end
                            default: begin
                                state_q <= StIdle;
                            end
                        endcase
                    end
                end else begin
                    presc_q <= presc_q + DIV_BITS'(1);
                end
            end
        end
    end

    assign busy    = (state_q != StIdle);
    assign rdy     = (state_q == StIdle);
    assign done    = done_q;
    assign aborted = aborted_q;
    assign out_cmp = cur_q;

endmodule

// File: tb/tb_servo_ramp_profile.sv
// Directed bench for servo_ramp_profile with hand-computed position sequences.
module tb_servo_ramp_profile;

    logic        clk;
    logic        rst_n;
    logic [15:0] start_pos, end_pos, max_speed, accel;
    logic [15:0] tick_div;
    logic        go, abort;
    logic        busy, rdy, done, aborted;
    logic [15:0] out_cmp;

    int n_checks;
    int n_errors;
    int exp_q[$];

    servo_ramp_profile #(
        .CNTR_BITS(16),
        .DIV_BITS (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_pos(start_pos),
        .end_pos  (end_pos),
        .max_speed(max_speed),
        .accel    (accel),
        .tick_div (tick_div),
        .go       (go),
        .abort    (abort),
        .busy     (busy),
        .rdy      (rdy),
        .done     (done),
        .aborted  (aborted),
        .out_cmp  (out_cmp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse go for one edge; afterwards out_cmp shows start (clock 1 after go)
    task automatic start_move(input int s, input int e, input int vmax, input int acc,
                              input int div);
        start_pos = 16'(s);
        end_pos   = 16'(e);
        max_speed = 16'(vmax);
        accel     = 16'(acc);
        tick_div  = 16'(div);
        go        = 1'b1;
        step();
        go        = 1'b0;
    endtask

    // Walks exp_q one cycle per entry; done/busy must change only on the last entry
    task automatic run_seq(input string tag);
        for (int i = 0; i < exp_q.size(); i++) begin
            bit last;
            last = (i == exp_q.size() - 1);
            check_eq($sformatf("%s_pos[%0d]", tag, i), int'(out_cmp), exp_q[i]);
            check_eq($sformatf("%s_done[%0d]", tag, i), int'(done), last ? 1 : 0);
            check_eq($sformatf("%s_busy[%0d]", tag, i), int'(busy), last ? 0 : 1);
            if (!last) step();
        end
        step();
        check_eq($sformatf("%s_done_after", tag), int'(done), 0);
    endtask

    int trap[15] = '{0, 2, 6, 12, 20, 30, 40, 50, 60, 70, 80, 88, 94, 98, 100};

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        go        = 1'b0;
        abort     = 1'b0;
        start_pos = '0;
        end_pos   = '0;
        max_speed = '0;
        accel     = '0;
        tick_div  = '0;
        #12;
        check_eq("rst_out_cmp", int'(out_cmp), 0);
        check_eq("rst_rdy", int'(rdy), 1);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_aborted", int'(aborted), 0);
        rst_n = 1'b1;
        step();

        // Trapezoid up
        start_move(0, 100, 10, 2, 0);
        exp_q.delete();
        foreach (trap[i]) exp_q.push_back(trap[i]);
        run_seq("trap");

        // Triangle
        start_move(0, 10, 10, 2, 0);
        exp_q = '{0, 2, 6, 10};
        run_seq("tri");

        // Downward mirror
        start_move(100, 0, 10, 2, 0);
        exp_q.delete();
        foreach (trap[i]) exp_q.push_back(100 - trap[i]);
        run_seq("down");

        // Prescaler: value changes every 4th clock, done on clock 57 counting go edge as 1
        start_move(0, 100, 10, 2, 3);
        for (int k = 0; k <= 56; k++) begin
            check_eq($sformatf("div_pos[%0d]", k), int'(out_cmp), trap[k / 4]);
            check_eq($sformatf("div_done[%0d]", k), int'(done), (k == 56) ? 1 : 0);
            if (k < 56) step();
        end

        // Abort at 50
        start_move(0, 100, 10, 2, 0);
        for (int i = 0; i < 20 && out_cmp != 16'd50; i++) step();
        check_eq("abort_reach50", int'(out_cmp), 50);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_eq("abort_pos", int'(out_cmp), 50);
        check_eq("abort_rdy", int'(rdy), 1);
        check_eq("abort_flag", int'(aborted), 1);
        check_eq("abort_done", int'(done), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq($sformatf("abort_hold[%0d]", i), int'(out_cmp), 50);
            check_eq($sformatf("abort_nodone[%0d]", i), int'(done), 0);
            check_eq($sformatf("abort_sticky[%0d]", i), int'(aborted), 1);
        end

        // Zero-length move clears aborted and pulses done
        start_move(50, 50, 10, 2, 0);
        check_eq("zero_done", int'(done), 1);
        check_eq("zero_aborted", int'(aborted), 0);
        check_eq("zero_rdy", int'(rdy), 1);
        check_eq("zero_pos", int'(out_cmp), 50);
        step();
        check_eq("zero_done_after", int'(done), 0);

        // Retarget during cruise
        start_move(0, 100, 10, 2, 0);
        for (int i = 0; i < 20 && out_cmp != 16'd40; i++) step();
        check_eq("retgt_reach40", int'(out_cmp), 40);
        start_move(0, 20, 10, 2, 0);
        exp_q = '{0, 2, 6, 12, 18, 20};
        run_seq("retgt");

        // Degenerate accel/speed
        start_move(5, 8, 0, 0, 0);
        exp_q = '{5, 6, 7, 8};
        run_seq("degen");

        // Asynchronous reset mid-move
        start_move(0, 100, 10, 2, 0);
        for (int i = 0; i < 20 && out_cmp != 16'd40; i++) step();
        check_eq("arst_reach40", int'(out_cmp), 40);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_out_cmp", int'(out_cmp), 0);
        check_eq("arst_rdy", int'(rdy), 1);
        check_eq("arst_busy", int'(busy), 0);
        check_eq("arst_done", int'(done), 0);
        #10;
        rst_n = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/servo_ramp_profile.md
Name: servo_ramp_profile

Overview:
Single-axis servo position ramp generator with a trapezoidal velocity profile. It is the successor to the constant-speed servo stepper: it adds acceleration, deceleration, a programmable update-rate prescaler, abort, and busy/done handshaking. It sits between the command logic and the PWM compare stage, and its out_cmp drives the PWM comparator directly.

Parameters:
CNTR_BITS, 16, width of positions, velocity, acceleration and out_cmp
DIV_BITS, 16, width of the update-tick prescaler

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  reset, asynchronous, active-low
start_pos  in  CNTR_BITS  move start position, sampled on go
end_pos  in  CNTR_BITS  move target position, sampled on go
max_speed  in  CNTR_BITS  cruise velocity in counts/tick, sampled on go; 0 is treated as 1
accel  in  CNTR_BITS  velocity change per tick, sampled on go; 0 is treated as 1
tick_div  in  DIV_BITS  profile update every tick_div+1 clocks, sampled on go
go  in  1  start a move; single-cycle pulse or level (re-triggers each cycle while high)
abort  in  1  stop the move at the current position
busy  out  1  move in progress (state != IDLE)
rdy  out  1  ~busy
done  out  1  one-cycle pulse on normal arrival at target
aborted  out  1  sticky; set by abort, cleared by go or reset
out_cmp  out  CNTR_BITS  current position (registered)

Behaviour:
- Reset (async, rst_n=0) clears the following: state=IDLE, cur=0, end_reg=0, vel=0, ramp_dist=0, prescaler=0, done=0, aborted=0. After reset, out_cmp=0, rdy=1, busy=0.
- Registers: cur, end_reg, vmax_reg, acc_reg, div_reg, vel (CNTR_BITS), ramp_dist (CNTR_BITS, saturating at all-ones), prescaler (DIV_BITS).
- FSM states: IDLE, ACCEL, CRUISE, DECEL.
- go has the highest priority in any state, including over abort and mid-move. On the next edge after go:
  - cur=start_pos, end_reg=end_pos, profile regs latched, vel=0, ramp_dist=0, prescaler=0, aborted=0.
  - If start_pos==end_pos: state=IDLE and done=1 for that cycle. Otherwise state=ACCEL.
- Tick: prescaler counts 0..div_reg while busy. A tick occurs in the cycle where prescaler==div_reg, and prescaler then wraps to 0. With tick_div=0, every cycle is a tick. No position update happens off-tick.
- On each tick, let rem=|end_reg-cur|. The direction is toward end_reg; up and down moves are symmetric.
  - ACCEL: vel_n = min(vel+acc_reg, vmax_reg), summed at CNTR_BITS+1 bits. step = min(vel_n, rem). cur moves by step. ramp_dist += step (saturating). vel=vel_n.
    - Next state is DECEL if (rem-step) <= ramp_dist (this takes priority).
    - Otherwise CRUISE if vel_n==vmax_reg.
    - Otherwise stay in ACCEL.
  - CRUISE: step = min(vel, rem). cur moves by step. Go to DECEL if (rem-step) <= ramp_dist.
  - DECEL: step = min(vel, rem). cur moves by step. Then vel = max(vel-acc_reg, 1), so velocity never reaches 0 before arrival.
  - In any moving state, if rem-step==0: state=IDLE, vel=0, done=1 for exactly one cycle. The done pulse coincides with the first cycle in which out_cmp==end_reg.
- Position never overshoots end_reg. No wrap-around is possible, because step <= rem.
- abort while busy and without go: on the next edge, state=IDLE, end_reg=cur, vel=0, aborted=1, done stays 0, out_cmp is held. abort while IDLE has no effect.
- done is 0 in all cycles except the arrival pulse and the zero-length-move pulse.
- Profile inputs are ignored between go pulses.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-move (cur=40) -> out_cmp=0, rdy=1, busy=0, done=0 immediately, without waiting for a clock edge.
- Trapezoid, with start=0, end=100, accel=2, max_speed=10, tick_div=0 -> out_cmp on successive cycles after go = 0,2,6,12,20,30,40,50,60,70,80,88,94,98,100. done is high only in the cycle out_cmp=100 first appears, and busy falls in that same cycle.
- Triangle and downward moves:
  - start=0, end=10, accel=2, max=10 -> 0,2,6,10 with done at 10.
  - start=100, end=0 with the same profile as the trapezoid test -> mirror sequence 100,98,94,...,2,0.
- Prescaler: trapezoid stimulus with tick_div=3 -> out_cmp changes only every 4th clock, with the same value sequence as the tick_div=0 case; done arrives on clock 57 after go.
- Abort and retarget:
  - abort at out_cmp=50 -> holds 50, rdy=1, aborted=1, no done pulse.
  - A subsequent go with start=50, end=50 -> done pulse next cycle and aborted=0.
  - go during CRUISE with start=0, end=20 -> restarts at 0 and follows the ACCEL profile from vel=0.
- Degenerate inputs: accel=0, max_speed=0, start=5, end=8 -> out_cmp 5,6,7,8 at one count per tick, done at 8.
